// File: rtl/layer1_neuron_mac.sv
// Layer-1 neuron engine: per neuron, MAC over N_IN pixel*weight products,
// add bias, then saturate to 16 bits and apply ReLU. Memories are
// combinational-read, so all read addresses come straight from registered
// counters.
//
//   state  | meaning
//   IDLE   | waiting for start
//   MAC    | one pixel*weight product accumulated per cycle
//   BIAS   | neuron bias added (aligned to Q16.16)
//   EMIT   | activation computed and registered, accumulator cleared
//   DONE   | last neuron emitted, one-cycle done pulse follows
module layer1_neuron_mac #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 8,
    parameter int WA_W  = 13,
    parameter int PA_W  = 10,
    parameter int ACC_W = 42
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [PA_W-1:0]   px_addr,
    input  logic [15:0]       px_data,
    output logic [WA_W-1:0]   wt_addr,
    input  logic [15:0]       wt_data,
    output logic [7:0]        bias_addr,
    input  logic [15:0]       bias_data,
    output logic              out_valid,
    output logic [7:0]        out_idx,
    output logic [15:0]       out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_BIAS,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               neuron_q, neuron_d;
    logic [PA_W-1:0]          i_q, i_d;
    logic [WA_W-1:0]          wt_q, wt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic                     done_q, done_d;
    logic [7:0]               out_idx_q, out_idx_d;
    logic [15:0]              out_data_q, out_data_d;

    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [15:0]              act;

    // Full-precision Q16.16 product; operands widened so the 32-bit result is exact.
    assign prod     = $signed({{16{px_data[15]}}, px_data}) * $signed({{16{wt_data[15]}}, wt_data});
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign bias_ext = {{(ACC_W-24){bias_data[15]}}, bias_data, 8'h00};
    assign acc_shr  = acc_q >>> 8;

    // Saturate to signed 16 and apply ReLU in one step: negatives go to 0,
    // anything with magnitude bits above bit 14 clamps to 0x7FFF.
    always_comb begin
        act = 16'h0000;
        if (acc_shr[ACC_W-1]) begin
            act = 16'h0000;
        end else if (|acc_shr[ACC_W-2:15]) begin
            act = 16'h7FFF;
        end else begin
            act = {1'b0, acc_shr[14:0]};
        end
    end

    // Next-state, counter and accumulator logic.
    always_comb begin
        state_d     = state_q;
        neuron_d    = neuron_q;
        i_d         = i_q;
        wt_d        = wt_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_MAC;
                    neuron_d = 8'd0;
                    i_d      = '0;
                    wt_d     = '0;
                    acc_d    = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                i_d   = i_q + PA_W'(1);
                wt_d  = wt_q + WA_W'(1);
                if (i_q == PA_W'(N_IN - 1)) begin
                    i_d     = '0;
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                acc_d   = acc_q + bias_ext;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                out_valid_d = 1'b1;
                out_idx_d   = neuron_q;
                out_data_d  = act;
                acc_d       = '0;
                i_d         = '0;
                if (neuron_q == 8'(N_OUT - 1)) begin
                    // Neuron index returns to 0 so bias_addr reads 0 in DONE/IDLE.
                    neuron_d = 8'd0;
                    state_d  = S_DONE;
                end else begin
                    neuron_d = neuron_q + 8'd1;
                    state_d  = S_MAC;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            neuron_q    <= 8'd0;
            i_q         <= '0;
            wt_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_idx_q   <= 8'd0;
            out_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            neuron_q    <= neuron_d;
            i_q         <= i_d;
            wt_q        <= wt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    // Read addresses and status outputs.
    always_comb begin
        busy      = (state_q != S_IDLE);
        px_addr   = (state_q == S_MAC) ? i_q  : '0;
        wt_addr   = (state_q == S_MAC) ? wt_q : '0;
        bias_addr = neuron_q;
        out_valid = out_valid_q;
        done      = done_q;
        out_idx   = out_idx_q;
        out_data  = out_data_q;
    end

endmodule

// File: tb/tb_layer1_neuron_mac.sv
// Bench for layer1_neuron_mac with a small layer (4 inputs, 3 neurons).
module tb_layer1_neuron_mac;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int WA_W  = 4;
    localparam int PA_W  = 2;
    localparam int ACC_W = 42;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy;
    logic             done;
    logic [PA_W-1:0]  px_addr;
    logic [15:0]      px_data;
    logic [WA_W-1:0]  wt_addr;
    logic [15:0]      wt_data;
    logic [7:0]       bias_addr;
    logic [15:0]      bias_data;
    logic             out_valid;
    logic [7:0]       out_idx;
    logic [15:0]      out_data;

    logic signed [15:0] px_mem   [4];
    logic signed [15:0] wt_mem   [16];
    logic signed [15:0] bias_mem [3];

    logic [23:0] sb [$];
    int n_cmp  = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    logic [WA_W-1:0] wt_log [32];

    always #5 clk = ~clk;

    assign px_data   = px_mem[px_addr];
    assign wt_data   = wt_mem[wt_addr];
    assign bias_data = (bias_addr < 8'd3) ? bias_mem[bias_addr[1:0]] : 16'h0000;

    layer1_neuron_mac #(
        .N_IN(N_IN), .N_OUT(N_OUT), .WA_W(WA_W), .PA_W(PA_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .px_addr(px_addr), .px_data(px_data),
        .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_addr(bias_addr), .bias_data(bias_data),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_act(input int n);
        longint acc;
        longint s;
        acc = 0;
        for (int i = 0; i < N_IN; i++)
            acc += longint'(px_mem[i]) * longint'(wt_mem[n*N_IN + i]);
        acc += longint'(bias_mem[n]) * 256;
        s = acc >>> 8;
        if (s < 0) return 16'h0000;
        if (s > 32767) return 16'h7FFF;
        return s[15:0];
    endfunction

    task automatic fill(input logic [15:0] px, input logic [15:0] wt,
                        input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
        for (int i = 0; i < 4; i++) px_mem[i] = px;
        for (int i = 0; i < 16; i++) wt_mem[i] = wt;
        bias_mem[0] = b0;
        bias_mem[1] = b1;
        bias_mem[2] = b2;
    endtask

    // Runs one pass; hold_start keeps start high until done is seen.
    task automatic run_pass(input string tag, input bit hold_start);
        int cyc;
        int done_cyc;
        int done_cnt;
        for (int n = 0; n < N_OUT; n++) sb.push_back({8'(n), model_act(n)});
        strobe_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        wt_log[0] = wt_addr;
        done_cyc = 0;
        done_cnt = 0;
        for (cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 32) wt_log[cyc] = wt_addr;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
                start = 1'b0;
            end
        end
        check({tag, "_done_latency"}, 32'(done_cyc), 32'd19);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_strobes"}, 32'(strobe_cnt), 32'd3);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard pop on every activation strobe.
    always @(negedge clk) begin
        logic [23:0] e;
        if (!reset && out_valid) begin
            strobe_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'(out_idx), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("out_idx", 32'(out_idx), 32'(e[23:16]));
                check("out_data", 32'(out_data), 32'(e[15:0]));
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-MAC
        fill(16'h0100, 16'h0080, 16'h0100, 16'h0000, 16'h0000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_wt_addr_running", 32'(wt_addr), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_px", 32'(px_addr), 32'd0);
        check("midrst_wt", 32'(wt_addr), 32'd0);
        check("midrst_bias", 32'(bias_addr), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        run_pass("t1_restart", 1'b0);

        // Bias only
        fill(16'h0100, 16'h0000, 16'h0100, 16'h0080, 16'h0000);
        check("t2_model0", 32'(model_act(0)), 32'h0100);
        run_pass("t2", 1'b0);

        // 1.0 * 0.5 * 4 + 1.0, plus weight address stepping
        fill(16'h0100, 16'h0080, 16'h0100, 16'h0000, 16'hFF00);
        run_pass("t3", 1'b0);
        for (int c = 0; c < 4; c++) check("t3_wt_addr_n0", 32'(wt_log[c]), 32'(c));
        check("t3_wt_addr_bias", 32'(wt_log[4]), 32'd0);
        for (int c = 6; c < 10; c++) check("t3_wt_addr_n1", 32'(wt_log[c]), 32'(c - 2));
        for (int c = 12; c < 16; c++) check("t3_wt_addr_n2", 32'(wt_log[c]), 32'(c - 4));

        // Negative sum -> ReLU to 0
        fill(16'h0100, 16'hFF00, 16'h0080, 16'h0080, 16'h0080);
        run_pass("t4", 1'b0);

        // Positive and negative saturation
        fill(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_pass("t5_pos", 1'b0);
        fill(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_pass("t5_neg", 1'b0);

        // Mixed values per neuron
        for (int i = 0; i < 4; i++) px_mem[i] = 16'(16'h0040 * (i + 1));
        for (int i = 0; i < 16; i++) wt_mem[i] = 16'($urandom_range(0, 16'hFFFF));
        bias_mem[0] = 16'hFE00;
        bias_mem[1] = 16'h0233;
        bias_mem[2] = 16'h0001;
        run_pass("mixed", 1'b0);

        // start held high through a whole pass
        fill(16'h0100, 16'h0080, 16'h0010, 16'h0020, 16'h0030);
        run_pass("t6_hold", 1'b1);
        run_pass("t6_next", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
